// File: rtl/geofence_driver.sv
// Collects 6-point cases into a ping-pong buffer and replays each case to a geofence receiver.
// Defining GEOFENCE_TIMEOUT_EN adds a watchdog that ends WAIT after TIMEOUT_CYC cycles.
//   state | meaning
//   IDLE  | receiver held in reset, waiting for a complete case and a free result slot
//   SEND  | geo_reset low, points 0..5 presented on X/Y/R one per cycle
//   WAIT  | geo_reset low, outputs zeroed, waiting for the receiver strobe
module geofence_driver #(
    parameter int TIMEOUT_CYC = 2047
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [9:0]  in_x,
    input  logic [9:0]  in_y,
    input  logic [10:0] in_r,
    output logic        geo_reset,
    output logic [9:0]  X,
    output logic [9:0]  Y,
    output logic [10:0] R,
    input  logic        valid,
    input  logic        is_inside,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_inside,
    output logic [7:0]  res_id,
    output logic        res_timeout
);

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("geofence_driver: TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t      state_q;
    logic [30:0] mem_q [2][6];
    logic [1:0]  full_q, full_d;
    logic        wr_bank_q, rd_bank_q;
    logic [2:0]  wr_idx_q, send_idx_q, rd_idx;
    logic [7:0]  case_cnt_q, res_id_q;
    logic        geo_reset_q, res_valid_q, res_inside_q;
    logic [9:0]  x_q, y_q;
    logic [10:0] r_q;
    logic [30:0] pt_next;
    logic        accept, set_done, start, last_pt, wait_done;

    assign in_ready = ~(full_q[0] & full_q[1]);
    assign accept   = in_valid & in_ready;
    assign set_done = accept && (wr_idx_q == 3'd5);
    assign start    = (state_q == IDLE) && full_q[rd_bank_q] && (!res_valid_q || res_ready);
    assign last_pt  = (state_q == SEND) && (send_idx_q == 3'd5);
    assign rd_idx   = (state_q == SEND && send_idx_q != 3'd5) ? send_idx_q + 3'd1 : 3'd0;
    assign pt_next  = mem_q[rd_bank_q][rd_idx];

`ifdef GEOFENCE_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_q;
    logic            res_timeout_q;
    logic            wait_to;
    assign wait_to     = !valid && (wd_q == '0);
    assign wait_done   = valid | wait_to;
    assign res_timeout = res_timeout_q;
`else
    assign wait_done   = valid;
    assign res_timeout = 1'b0;
`endif

    assign geo_reset  = geo_reset_q;
    assign X          = x_q;
    assign Y          = y_q;
    assign R          = r_q;
    assign res_valid  = res_valid_q;
    assign res_inside = res_inside_q;
    assign res_id     = res_id_q;

    // Point storage carries no reset; the full flags and write pointer decide what is live.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_bank_q][wr_idx_q] <= {in_x, in_y, in_r};
        end
    end

    // Freeing the sent bank and completing the other bank can land in the same cycle.
    always_comb begin
        full_d = full_q;
        if (last_pt) full_d[rd_bank_q] = 1'b0;
        if (set_done) full_d[wr_bank_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            wr_idx_q  <= 3'd0;
            rd_bank_q <= 1'b0;
        end else begin
            full_q <= full_d;
            if (accept) begin
                if (wr_idx_q == 3'd5) begin
                    wr_idx_q  <= 3'd0;
                    wr_bank_q <= ~wr_bank_q;
                end else begin
                    wr_idx_q <= wr_idx_q + 3'd1;
                end
            end
            if (last_pt) rd_bank_q <= ~rd_bank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            geo_reset_q  <= 1'b1;
            x_q          <= '0;
            y_q          <= '0;
            r_q          <= '0;
            send_idx_q   <= 3'd0;
            res_valid_q  <= 1'b0;
            res_inside_q <= 1'b0;
            res_id_q     <= 8'd0;
            case_cnt_q   <= 8'd0;
`ifdef GEOFENCE_TIMEOUT_EN
            wd_q          <= '0;
            res_timeout_q <= 1'b0;
`endif
        end else begin
            if (res_valid_q && res_ready) res_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q          <= SEND;
                        geo_reset_q      <= 1'b0;
                        {x_q, y_q, r_q}  <= pt_next;
                        send_idx_q       <= 3'd0;
                    end
                end
                SEND: begin
                    if (send_idx_q == 3'd5) begin
                        state_q         <= WAIT;
                        {x_q, y_q, r_q} <= '0;
`ifdef GEOFENCE_TIMEOUT_EN
                        wd_q            <= WD_W'(TIMEOUT_CYC - 1);
`endif
                    end else begin
                        {x_q, y_q, r_q} <= pt_next;
                        send_idx_q      <= send_idx_q + 3'd1;
                    end
                end
                WAIT: begin
                    if (wait_done) begin
                        state_q      <= IDLE;
                        geo_reset_q  <= 1'b1;
                        res_valid_q  <= 1'b1;
                        res_inside_q <= valid & is_inside;
                        res_id_q     <= case_cnt_q;
                        case_cnt_q   <= case_cnt_q + 8'd1;
`ifdef GEOFENCE_TIMEOUT_EN
                        res_timeout_q <= wait_to;
                    end else begin
                        wd_q <= wd_q - 1'b1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_geofence_driver.sv
// Bench for geofence_driver: vector table, directed corner sequences and a randomized scoreboard run.
module tb_geofence_driver;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, geo_reset, valid, is_inside;
    logic        res_valid, res_ready, res_inside, res_timeout;
    logic [9:0]  in_x, in_y, X, Y;
    logic [10:0] in_r, R;
    logic [7:0]  res_id;

    geofence_driver #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_r(in_r), .geo_reset(geo_reset),
        .X(X), .Y(Y), .R(R), .valid(valid), .is_inside(is_inside),
        .res_valid(res_valid), .res_ready(res_ready), .res_inside(res_inside),
        .res_id(res_id), .res_timeout(res_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic [9:0] x, y; logic [10:0] r; } pt_t;
    typedef struct packed { logic ins; logic [7:0] id; } res_t;
    typedef struct {
        logic iv; logic [9:0] x, y; logic [10:0] r; logic v, ins, rr;
        logic egr; logic [9:0] ex, ey; logic [10:0] er; logic erv, eri; logic [7:0] eid;
    } vec_t;

    pt_t  pq[$];
    int   bidx;
    int   exp_id;
    vec_t tbl [17];

    function automatic vec_t mk(logic iv, int x, int y, int r, logic v, logic ins, logic rr,
                                logic egr, int ex, int ey, int er, logic erv, logic eri, int eid);
        vec_t t;
        t.iv = iv; t.x = 10'(x); t.y = 10'(y); t.r = 11'(r);
        t.v = v; t.ins = ins; t.rr = rr;
        t.egr = egr; t.ex = 10'(ex); t.ey = 10'(ey); t.er = 11'(er);
        t.erv = erv; t.eri = eri; t.eid = 8'(eid);
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; valid = 1'b0; is_inside = 1'b0; res_ready = 1'b0;
        in_x = '0; in_y = '0; in_r = '0;
        tick(); tick();
        reset = 1'b0;
        pq.delete(); bidx = 0; exp_id = 0;
    endtask

    task automatic push_n(input int n, input int chk_full_at);
        int cnt = 0;
        int guard = 0;
        while (cnt < n && guard < 2000) begin
            pt_t  p;
            logic rdy;
            p.x = 10'($urandom_range(0, 1023));
            p.y = 10'($urandom_range(0, 1023));
            p.r = 11'($urandom_range(0, 2047));
            in_valid = 1'b1; in_x = p.x; in_y = p.y; in_r = p.r;
            rdy = in_ready;
            tick();
            guard++;
            if (rdy) begin
                pq.push_back(p);
                cnt++;
                if (cnt == chk_full_at) chk("in_ready_both_full", in_ready, 0);
            end
        end
        in_valid = 1'b0;
        if (cnt < n) chk("push_budget", cnt, n);
    endtask

    task automatic wait_geo_low(output bit ok);
        int g = 0;
        while (geo_reset !== 1'b0 && g < 300) begin
            tick();
            g++;
        end
        ok = (geo_reset === 1'b0);
        if (!ok) chk("burst_start_timeout", geo_reset, 0);
    endtask

    task automatic rx_burst(input logic ins, input int dly);
        bit ok;
        wait_geo_low(ok);
        if (ok) begin
            for (int k = 0; k < 6; k++) begin
                int idx = bidx * 6 + k;
                chk("burst_geo", geo_reset, 0);
                if (idx < pq.size()) begin
                    chk("burst_x", X, pq[idx].x);
                    chk("burst_y", Y, pq[idx].y);
                    chk("burst_r", R, pq[idx].r);
                end else begin
                    chk("burst_point_known", idx, pq.size());
                end
                tick();
            end
            bidx++;
            for (int d = 0; d < dly; d++) begin
                chk("wait_geo", geo_reset, 0);
                chk("wait_xyr", {X, Y, R}, 0);
                tick();
            end
            valid = 1'b1; is_inside = ins;
            tick();
            valid = 1'b0;
            chk("res_valid", res_valid, 1);
            chk("res_inside", res_inside, ins);
            chk("res_id", res_id, exp_id);
            chk("res_timeout", res_timeout, 0);
            chk("geo_after_result", geo_reset, 1);
            exp_id++;
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int w;

        do_reset();
        chk("rst_geo", geo_reset, 1);
        chk("rst_xyr", {X, Y, R}, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_inside", res_inside, 0);
        chk("rst_res_timeout", res_timeout, 0);
        chk("rst_res_id", res_id, 0);

        // Single case: points pushed, burst replayed, strobes in IDLE and SEND ignored
        tbl[0]  = mk(1, 0, 0, 5,   0, 0, 0,  1, 0, 0, 0,    0, 0, 0);
        tbl[1]  = mk(1, 10, 0, 5,  0, 0, 0,  1, 0, 0, 0,    0, 0, 0);
        tbl[2]  = mk(1, 15, 8, 5,  0, 0, 0,  1, 0, 0, 0,    0, 0, 0);
        tbl[3]  = mk(1, 10, 16, 5, 1, 1, 0,  1, 0, 0, 0,    0, 0, 0);
        tbl[4]  = mk(1, 0, 16, 5,  0, 0, 0,  1, 0, 0, 0,    0, 0, 0);
        tbl[5]  = mk(1, 5, 8, 5,   0, 0, 0,  1, 0, 0, 0,    0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0,   0, 0, 0,  0, 0, 0, 5,    0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0,   0, 0, 0,  0, 10, 0, 5,   0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0,   0, 0, 0,  0, 15, 8, 5,   0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0,   1, 1, 0,  0, 10, 16, 5,  0, 0, 0);
        tbl[10] = mk(0, 0, 0, 0,   0, 0, 0,  0, 0, 16, 5,   0, 0, 0);
        tbl[11] = mk(0, 0, 0, 0,   0, 0, 0,  0, 5, 8, 5,    0, 0, 0);
        tbl[12] = mk(0, 0, 0, 0,   0, 0, 0,  0, 0, 0, 0,    0, 0, 0);
        tbl[13] = mk(0, 0, 0, 0,   1, 1, 0,  1, 0, 0, 0,    1, 1, 0);
        tbl[14] = mk(0, 0, 0, 0,   0, 0, 0,  1, 0, 0, 0,    1, 1, 0);
        tbl[15] = mk(0, 0, 0, 0,   0, 0, 1,  1, 0, 0, 0,    0, 0, 0);
        tbl[16] = mk(0, 0, 0, 0,   0, 0, 0,  1, 0, 0, 0,    0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            in_valid = tbl[i].iv; in_x = tbl[i].x; in_y = tbl[i].y; in_r = tbl[i].r;
            valid = tbl[i].v; is_inside = tbl[i].ins; res_ready = tbl[i].rr;
            tick();
            chk($sformatf("vec%0d_geo", i), geo_reset, tbl[i].egr);
            chk($sformatf("vec%0d_x", i), X, tbl[i].ex);
            chk($sformatf("vec%0d_y", i), Y, tbl[i].ey);
            chk($sformatf("vec%0d_r", i), R, tbl[i].er);
            chk($sformatf("vec%0d_res_valid", i), res_valid, tbl[i].erv);
            chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
            if (tbl[i].erv) begin
                chk($sformatf("vec%0d_res_inside", i), res_inside, tbl[i].eri);
                chk($sformatf("vec%0d_res_id", i), res_id, tbl[i].eid);
                chk($sformatf("vec%0d_res_timeout", i), res_timeout, 0);
            end
        end
        valid = 1'b0; res_ready = 1'b0;

        // Back-to-back: second burst begins the cycle after geo_reset reasserts
        do_reset();
        res_ready = 1'b1;
        fork
            push_n(12, 0);
            begin
                rx_burst(1'b0, 2);
                tick();
                chk("b2b_second_start", geo_reset, 0);
                rx_burst(1'b1, 1);
            end
        join
        res_ready = 1'b0;

        // Backpressure: results held, one burst released per accepted result
        do_reset();
        fork
            push_n(18, 12);
            rx_burst(1'b1, 1);
        join
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold_in_ready", in_ready, 0);
            chk("bp_hold_res_valid", res_valid, 1);
            chk("bp_hold_res_id", res_id, 0);
            chk("bp_hold_geo", geo_reset, 1);
            tick();
        end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        chk("bp_release1_res_valid", res_valid, 0);
        chk("bp_release1_geo", geo_reset, 0);
        rx_burst(1'b0, 0);
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold2_geo", geo_reset, 1);
            chk("bp_hold2_res_id", res_id, 1);
            chk("bp_hold2_in_ready", in_ready, 1);
            tick();
        end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        rx_burst(1'b1, 0);
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        chk("bp_final_res_valid", res_valid, 0);

        // Watchdog behaviour depends on the build
        do_reset();
        res_ready = 1'b1;
        push_n(6, 0);
        wait_geo_low(ok);
        repeat (6) tick();
`ifdef GEOFENCE_TIMEOUT_EN
        w = 0;
        while (res_valid !== 1'b1 && w < 200) begin
            tick();
            w++;
        end
        chk("wd_wait_cycles", w, 16);
        chk("wd_res_timeout", res_timeout, 1);
        chk("wd_res_inside", res_inside, 0);
        chk("wd_res_id", res_id, 0);
        chk("wd_geo", geo_reset, 1);
        bidx = 1; exp_id = 1;
        push_n(6, 0);
        rx_burst(1'b1, 1);
`else
        w = 0;
        repeat (100) begin
            tick();
            w++;
        end
        chk("nowd_geo", geo_reset, 0);
        chk("nowd_res_valid", res_valid, 0);
        chk("nowd_xyr", {X, Y, R}, 0);
        valid = 1'b1; tick(); valid = 1'b0;
        chk("nowd_late_res_valid", res_valid, 1);
        chk("nowd_late_res_id", res_id, 0);
`endif
        res_ready = 1'b0;

        // Reset in the middle of a burst discards all buffered points
        do_reset();
        res_ready = 1'b1;
        fork
            push_n(9, 0);
            begin
                wait_geo_low(ok);
                tick(); tick(); tick();
                chk("mid_send_point3_x", X, pq[3].x);
                reset = 1'b1; tick(); reset = 1'b0;
                chk("mid_rst_geo", geo_reset, 1);
                chk("mid_rst_xyr", {X, Y, R}, 0);
                chk("mid_rst_in_ready", in_ready, 1);
                chk("mid_rst_res_id", res_id, 0);
                chk("mid_rst_res_valid", res_valid, 0);
            end
        join
        pq.delete(); bidx = 0; exp_id = 0;
        push_n(3, 0);
        for (int i = 0; i < 20; i++) begin
            chk("mid_rst_no_burst", geo_reset, 1);
            tick();
        end
        push_n(3, 0);
        rx_burst(1'b1, 0);
        res_ready = 1'b0;

        // Randomized traffic against a set/result scoreboard
        begin
            pt_t        all[$];
            res_t       rq[$];
            res_t       nxt;
            bit         nxt_v, prev_idle, prev_start;
            int         acc, sent, bpos, bnum, wcnt, wdly;
            logic [7:0] nid;
            do_reset();
            all.delete(); rq.delete();
            nxt_v = 0; prev_idle = 0; prev_start = 0;
            acc = 0; sent = 0; bpos = 0; bnum = 0; wcnt = 0; wdly = 2; nid = 8'd0;
            for (int c = 0; c < 5000; c++) begin
                int   unsent;
                bit   in_wait, exp_start;
                pt_t  p;
                if (nxt_v) begin
                    rq.push_back(nxt);
                    nxt_v = 0;
                end
                unsent = acc / 6 - sent;
                chk("rnd_in_ready", in_ready, (unsent < 2));
                if (prev_idle) chk("rnd_start", geo_reset, !prev_start);
                chk("rnd_res_valid", res_valid, (rq.size() != 0));
                if (res_valid === 1'b1 && rq.size() != 0) begin
                    chk("rnd_res_inside", res_inside, rq[0].ins);
                    chk("rnd_res_id", res_id, rq[0].id);
                    chk("rnd_res_timeout", res_timeout, 0);
                end
                in_wait = 0;
                if (geo_reset === 1'b0) begin
                    if (bpos < 6) begin
                        if (bnum * 6 + bpos < all.size()) begin
                            chk("rnd_x", X, all[bnum * 6 + bpos].x);
                            chk("rnd_y", Y, all[bnum * 6 + bpos].y);
                            chk("rnd_r", R, all[bnum * 6 + bpos].r);
                        end else begin
                            chk("rnd_point_known", bnum * 6 + bpos, all.size());
                        end
                        bpos++;
                        if (bpos == 6) begin
                            sent++;
                            bnum++;
                        end
                    end else begin
                        in_wait = 1;
                        chk("rnd_wait_xyr", {X, Y, R}, 0);
                    end
                end else begin
                    chk("rnd_burst_len", (bpos == 0 || bpos == 6), 1);
                    chk("rnd_idle_xyr", {X, Y, R}, 0);
                    bpos = 0;
                    wcnt = 0;
                end
                res_ready = ($urandom_range(0, 2) != 0);
                exp_start = (geo_reset === 1'b1) && (unsent > 0) && (rq.size() == 0 || res_ready);
                prev_idle = (geo_reset === 1'b1);
                prev_start = exp_start;
                if (rq.size() != 0 && res_ready) void'(rq.pop_front());
                valid = 1'b0;
                is_inside = 1'($urandom_range(0, 1));
                if (in_wait) begin
                    if (wcnt >= wdly) begin
                        valid = 1'b1;
                        nxt.ins = is_inside;
                        nxt.id = nid;
                        nxt_v = 1;
                        nid = nid + 8'd1;
                        wcnt = 0;
                        wdly = $urandom_range(0, 3);
                    end else begin
                        wcnt++;
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    valid = 1'b1;
                end
                p.x = 10'($urandom_range(0, 1023));
                p.y = 10'($urandom_range(0, 1023));
                p.r = 11'($urandom_range(0, 2047));
                in_valid = ($urandom_range(0, 3) != 0);
                in_x = p.x; in_y = p.y; in_r = p.r;
                if (in_valid && unsent < 2) begin
                    all.push_back(p);
                    acc++;
                end
                tick();
            end
            in_valid = 1'b0; valid = 1'b0; res_ready = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
